config_sequencer: RTL and testbench



---
 rtl/config_sequencer_pkg.sv | 21 ++
 rtl/config_table.sv | 47 ++++
 rtl/config_sequencer.sv | 139 +++++++++++++
 tb/tb_config_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_sequencer_pkg.sv
// Shared definitions for the configuration load/verify sequencer.
// State codes are plain constants so they line up with the legacy encoding.
package config_sequencer_pkg;

   localparam int unsigned DEF_NUM_WORDS  = 10;
   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_ADDR_WIDTH = 4;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t WRITE = 2'd1;
   localparam state_t READ  = 2'd2;
   localparam state_t DONE  = 2'd3;

   // True while a load/verify sequence owns the table.
   function automatic logic state_active(input state_t s);
      return (s == WRITE) || (s == READ);
   endfunction

endpackage

// File: rtl/config_table.sv
// Host-loaded parameter table: one synchronous write port and one
// asynchronous read port, cleared by reset.
module config_table
   import config_sequencer_pkg::*;
#(
   parameter int unsigned NUM_WORDS  = DEF_NUM_WORDS,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam logic [ADDR_WIDTH:0] NUM_WORDS_EXT = (ADDR_WIDTH+1)'(NUM_WORDS);

   logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
   logic [DATA_WIDTH-1:0] mem_d [NUM_WORDS];
   logic                  wr_hit;

   // Indices beyond the table are dropped rather than aliased.
   assign wr_hit = wr_en && ({1'b0, wr_addr} < NUM_WORDS_EXT);

   always_comb begin
      mem_d = mem_q;
      if (wr_hit) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/config_sequencer.sv
// Loads the parameter table into a target over valid/ready, then reads each
// entry back over req/ack and reports the first mismatching index.
module config_sequencer
   import config_sequencer_pkg::*;
#(
   parameter int unsigned NUM_WORDS  = DEF_NUM_WORDS,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cfg_wr_en,
   input  logic [ADDR_WIDTH-1:0] cfg_wr_addr,
   input  logic [DATA_WIDTH-1:0] cfg_wr_data,
   input  logic                  start,
   input  logic                  abort,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  rd_req,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  rd_ack,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH-1:0] err_addr
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic                  error_q, error_d;
   logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

   logic                  active;
   logic                  at_last;
   logic                  tbl_wr_en;
   logic [DATA_WIDTH-1:0] tbl_word;

   assign active    = state_active(state_q);
   assign at_last   = (idx_q == LAST_IDX);
   assign tbl_wr_en = cfg_wr_en && !active;

   config_table #(
      .NUM_WORDS (NUM_WORDS),
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_table (
      .clock  (clock),
      .reset  (reset),
      .wr_en  (tbl_wr_en),
      .wr_addr(cfg_wr_addr),
      .wr_data(cfg_wr_data),
      .rd_addr(idx_q),
      .rd_data(tbl_word)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      error_d    = error_q;
      err_addr_d = err_addr_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = WRITE;
               idx_d      = '0;
               error_d    = 1'b0;
               err_addr_d = '0;
            end
         end
         WRITE: begin
            if (abort) begin
               state_d = IDLE;
               idx_d   = '0;
            end else if (out_ready) begin
               if (at_last) begin
                  state_d = READ;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + ADDR_WIDTH'(1);
               end
            end
         end
         READ: begin
            // Abort wins even over an ack that carries a mismatch.
            if (abort) begin
               state_d = IDLE;
               idx_d   = '0;
            end else if (rd_ack) begin
               if (rd_data != tbl_word) begin
                  state_d    = DONE;
                  error_d    = 1'b1;
                  err_addr_d = idx_q;
               end else if (at_last) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + ADDR_WIDTH'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         error_q    <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         error_q    <= error_d;
         err_addr_q <= err_addr_d;
      end
   end

   // Address/data lines are forced low outside their phase so nothing stale leaks out.
   assign out_valid = (state_q == WRITE);
   assign out_addr  = out_valid ? idx_q : '0;
   assign out_data  = out_valid ? tbl_word : '0;
   assign out_last  = out_valid && at_last;
   assign rd_req    = (state_q == READ);
   assign rd_addr   = rd_req ? idx_q : '0;
   assign busy      = active;
   assign done      = (state_q == DONE);
   assign error     = error_q;
   assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_config_sequencer.sv
// Self-checking bench for config_sequencer: scenario table, hand-written
// abort/reset sequences and randomized runs against a transaction-level model.
module tb_config_sequencer;

   localparam int NW = 10;
   localparam int DW = 32;
   localparam int AW = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          cfg_wr_en;
   logic [AW-1:0] cfg_wr_addr;
   logic [DW-1:0] cfg_wr_data;
   logic          start;
   logic          abort;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_ack;
   logic [DW-1:0] rd_data;
   logic          busy;
   logic          done;
   logic          error;
   logic [AW-1:0] err_addr;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] tbl [NW];   // model of the host table
   logic [DW-1:0] tgt [NW];   // what the target has received

   config_sequencer #(
      .NUM_WORDS (NW),
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .cfg_wr_en  (cfg_wr_en),
      .cfg_wr_addr(cfg_wr_addr),
      .cfg_wr_data(cfg_wr_data),
      .start      (start),
      .abort      (abort),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_addr   (out_addr),
      .out_data   (out_data),
      .out_last   (out_last),
      .rd_req     (rd_req),
      .rd_addr    (rd_addr),
      .rd_ack     (rd_ack),
      .rd_data    (rd_data),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_addr   (err_addr)
   );

   always #5 clock = ~clock;

   typedef struct {
      int            rmode;      // 0 ready always, 1 ready alternating, 2 random
      int            adelay;     // ack delay in cycles, -1 random
      int            bidx;       // corrupted readback index, NW for none
      logic [DW-1:0] bval;
      int            inject;     // cycle to attempt a table write mid-sequence, 0 none
      int            exp_cyc;    // expected done cycle, 0 unchecked
      logic          exp_err;
      int            exp_eaddr;
   } scen_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic quiet();
      cfg_wr_en   = 1'b0;
      cfg_wr_addr = '0;
      cfg_wr_data = '0;
      start       = 1'b0;
      abort       = 1'b0;
      out_ready   = 1'b0;
      rd_ack      = 1'b0;
      rd_data     = '0;
   endtask

   task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      cfg_wr_en   = 1'b1;
      cfg_wr_addr = a;
      cfg_wr_data = d;
      tick();
      cfg_wr_en = 1'b0;
      if (int'(a) < NW) tbl[a] = d;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_err_addr"}, err_addr, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_addr"}, out_addr, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_out_last"}, out_last, 0);
      chk({tag, "_rd_req"}, rd_req, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
   endtask

   // One full sequence from IDLE/DONE; the target side is modelled here.
   task automatic run_seq(input int rmode, input int adelay, input int bidx,
                          input logic [DW-1:0] bval, input int inject, output int done_cyc);
      int   wr_cnt = 0;
      int   rd_cnt = 0;
      int   wc     = 0;
      int   cyc    = 0;
      int   dly;
      int   exp_reads;
      bit   fin    = 0;
      logic exp_err;
      exp_err   = (bidx < NW) && (bval != tbl[(bidx < NW) ? bidx : 0]);
      exp_reads = exp_err ? bidx + 1 : NW;
      done_cyc  = 0;
      dly       = (adelay < 0) ? int'($urandom_range(3, 0)) : adelay;
      quiet();
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 1;
      while (!fin && cyc < 600) begin
         quiet();
         if (done) begin
            fin      = 1;
            done_cyc = cyc;
         end else begin
            chk("busy_run", busy, 1);
            if (cyc == 1) chk("first_valid", out_valid, 1);
            if (out_valid) begin
               chk("wr_no_rdreq", rd_req, 0);
               chk("wr_addr", out_addr, wr_cnt);
               chk("wr_data", out_data, tbl[(wr_cnt < NW) ? wr_cnt : 0]);
               chk("wr_last", out_last, wr_cnt == NW - 1);
               case (rmode)
                  0:       out_ready = 1'b1;
                  1:       out_ready = cyc[0];
                  default: out_ready = 1'($urandom_range(1, 0));
               endcase
               if (rmode == 2) begin
                  rd_ack  = 1'($urandom_range(1, 0));
                  rd_data = $urandom;
               end
               if (out_ready) begin
                  if (int'(out_addr) < NW) tgt[out_addr] = out_data;
                  wr_cnt++;
               end
            end else begin
               chk("rd_req", rd_req, 1);
               chk("rd_addr", rd_addr, rd_cnt);
               if (rmode == 2) out_ready = 1'($urandom_range(1, 0));
               if (wc >= dly) begin
                  rd_ack  = 1'b1;
                  rd_data = (rd_cnt == bidx) ? bval : tgt[(int'(rd_addr) < NW) ? rd_addr : 0];
                  rd_cnt++;
                  wc  = 0;
                  dly = (adelay < 0) ? int'($urandom_range(3, 0)) : adelay;
               end else begin
                  wc++;
               end
            end
            if (cyc == inject) begin
               cfg_wr_en   = 1'b1;
               cfg_wr_addr = AW'(7);
               cfg_wr_data = ~tbl[7];
            end
            tick();
            cyc++;
         end
      end
      quiet();
      chk("seq_done", done, 1);
      chk("seq_error", error, exp_err);
      chk("seq_err_addr", err_addr, exp_err ? bidx : 0);
      chk("seq_writes", wr_cnt, NW);
      chk("seq_reads", rd_cnt, exp_reads);
      chk("seq_busy_end", busy, 0);
      tick();
      tick();
      chk("done_held", done, 1);
      chk("done_no_rdreq", rd_req, 0);
      chk("done_no_valid", out_valid, 0);
   endtask

   scen_t scen [6];
   int    dc;
   int    n;

   initial begin
      scen[0] = '{0, 0, NW, '0, 2, 21, 1'b0, 0};
      scen[1] = '{0, 0, 4, 32'hDEAD, 0, 16, 1'b1, 4};
      scen[2] = '{0, 0, 0, 32'hDEAD, 0, 12, 1'b1, 0};
      scen[3] = '{0, 0, 9, 32'hDEAD, 0, 21, 1'b1, 9};
      scen[4] = '{1, 0, NW, '0, 0, 0, 1'b0, 0};
      scen[5] = '{0, 1, NW, '0, 0, 31, 1'b0, 0};

      quiet();
      reset = 1'b1;
      tick();
      tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();
      check_all_zero("post_reset");

      for (int i = 0; i < NW; i++) tbl[i] = '0;
      for (int i = 0; i < NW; i++) host_wr(AW'(i), DW'(i));
      host_wr(AW'(12), 32'hFFFF_FFFF);

      for (int s = 0; s < 6; s++) begin
         run_seq(scen[s].rmode, scen[s].adelay, scen[s].bidx, scen[s].bval, scen[s].inject, dc);
         chk("scen_error", error, scen[s].exp_err);
         chk("scen_err_addr", err_addr, scen[s].exp_eaddr);
         if (scen[s].exp_cyc != 0) chk("scen_done_cycle", dc, scen[s].exp_cyc);
      end

      // Abort while DONE changes nothing.
      run_seq(0, 0, 4, 32'hDEAD, 0, dc);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      chk("abort_done_done", done, 1);
      chk("abort_done_error", error, 1);
      chk("abort_done_err_addr", err_addr, 4);

      // Table is writable again once DONE.
      host_wr(AW'(5), 32'h55AA_33CC);
      run_seq(0, 0, NW, '0, 0, dc);

      // Abort during WRITE at index 3 with a same-cycle handshake.
      quiet();
      start = 1'b1;
      tick();
      start = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (!(out_valid && out_addr == AW'(3)) && n < 50) begin
         tick();
         n++;
      end
      chk("abort_wr_reach", out_addr, 3);
      abort = 1'b1;
      out_ready = 1'b1;
      tick();
      quiet();
      chk("abort_wr_busy", busy, 0);
      chk("abort_wr_done", done, 0);
      chk("abort_wr_valid", out_valid, 0);
      chk("abort_wr_rdreq", rd_req, 0);
      run_seq(0, 0, NW, '0, 0, dc);
      chk("restart_done_cycle", dc, 21);

      // Abort during READ beats a same-cycle mismatching ack.
      quiet();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!(rd_req && rd_addr == AW'(2)) && n < 60) begin
         out_ready = 1'b1;
         rd_ack    = rd_req;
         rd_data   = tbl[(int'(rd_addr) < NW) ? rd_addr : 0];
         tick();
         n++;
      end
      chk("abort_rd_reach", rd_addr, 2);
      abort   = 1'b1;
      rd_ack  = 1'b1;
      rd_data = 32'hDEAD;
      tick();
      quiet();
      chk("abort_rd_busy", busy, 0);
      chk("abort_rd_done", done, 0);
      chk("abort_rd_error", error, 0);
      chk("abort_rd_rdreq", rd_req, 0);

      // Randomized runs against the transaction model.
      for (int r = 0; r < 25; r++) begin
         for (int k = 0; k < 6; k++) host_wr(AW'($urandom_range(15, 0)), $urandom);
         run_seq(2, -1, int'($urandom_range(NW, 0)), $urandom, int'($urandom_range(8, 0)), dc);
      end

      // Reset mid-READ clears outputs at once and wipes the table.
      for (int i = 0; i < NW; i++) host_wr(AW'(i), 32'hA5A5_0000 | DW'(i));
      quiet();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!rd_req && n < 40) begin
         out_ready = 1'b1;
         tick();
         n++;
      end
      quiet();
      chk("reset_reach_read", rd_req, 1);
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(posedge clock);
      #1;
      reset = 1'b0;
      tick();
      for (int i = 0; i < NW; i++) tbl[i] = '0;
      run_seq(0, 0, NW, '0, 0, dc);
      chk("zero_table_done_cycle", dc, 21);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
